usb_uart_tx_buffer: RTL and testbench

Byte-wide transmit buffer between on-chip producers (message generators, formatters) and the `usb_uart` CDC core, all on `clk_48mhz`. It accepts bytes on a valid/ready interface and stores them in a power-of-two FIFO. A drain FSM delivers them to `usb_uart` using its `uart_we`/`uart_wait` write protocol, including the mandatory idle cycle between write strobes. Producers never see `uart_wait` and can burst whole strings without pacing logic.

---
 rtl/usb_uart_pkg.sv | 14 +
 rtl/sync_fifo_bram.sv | 68 ++++++
 rtl/usb_uart_tx_buffer.sv | 96 +++++++++
 tb/tb_usb_uart_tx_buffer.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_uart_pkg.sv
// Shared constants and the drain-state type for the usb_uart byte buffers.
// The TX buffer and the planned RX line buffer both build on these.
package usb_uart_pkg;

  localparam int USB_UART_DW       = 8;
  localparam int USB_UART_TX_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_STROBE = 2'd2
  } drain_state_e;

endpackage

// File: rtl/sync_fifo_bram.sv
// Single-clock FIFO with one synchronous write port and one registered read port,
// shaped so the storage maps onto one block RAM (no read-during-write bypass).
module sync_fifo_bram
  import usb_uart_pkg::*;
#(
  parameter int DW    = USB_UART_DW,
  parameter int DEPTH = USB_UART_TX_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_48mhz,
  input  logic          resetn,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic [AW:0]   level_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_fire, rd_fire;

  assign full_o    = (level_q == LVL_FULL);
  assign empty_o   = (level_q == '0);
  assign wr_fire   = wr_en_i && !full_o;
  assign rd_fire   = rd_en_i && !empty_o;
  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage and read register stay reset-free so the RAM primitive absorbs both.
  always_ff @(posedge clk_48mhz) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
    if (rd_fire) rd_data_q <= mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/usb_uart_tx_buffer.sv
// Transmit byte buffer in front of usb_uart: FIFO plus a drain FSM speaking uart_we/uart_wait.
//   state     | meaning
//   ST_IDLE   | uart_we low (gap cycle); pops the FIFO when a byte is stored
//   ST_FETCH  | popped byte in hand; loads uart_di and raises uart_we once uart_wait is low
//   ST_STROBE | uart_we high; byte accepted on the first cycle uart_wait is low
module usb_uart_tx_buffer
  import usb_uart_pkg::*;
#(
  parameter int DEPTH = USB_UART_TX_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_48mhz,
  input  logic                   resetn,
  input  logic [USB_UART_DW-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [AW:0]            level,
  output logic                   empty,
  output logic                   full,
  output logic [USB_UART_DW-1:0] uart_di,
  output logic                   uart_we,
  input  logic                   uart_wait
);

  drain_state_e           state_q, state_d;
  logic                   uart_we_q, uart_we_d;
  logic [USB_UART_DW-1:0] uart_di_q, uart_di_d;
  logic [USB_UART_DW-1:0] fifo_rd_data;
  logic                   rd_en;

  sync_fifo_bram #(
    .DW    (USB_UART_DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_48mhz (clk_48mhz),
    .resetn    (resetn),
    .wr_en_i   (in_valid),
    .wr_data_i (in_data),
    .rd_en_i   (rd_en),
    .rd_data_o (fifo_rd_data),
    .level_o   (level),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign in_ready = !full;
  assign uart_we  = uart_we_q;
  assign uart_di  = uart_di_q;

  always_comb begin
    state_d   = state_q;
    uart_we_d = uart_we_q;
    uart_di_d = uart_di_q;
    rd_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        uart_we_d = 1'b0;
        if (!empty) begin
          rd_en   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!uart_wait) begin
          uart_di_d = fifo_rd_data;
          uart_we_d = 1'b1;
          state_d   = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (!uart_wait) begin
          uart_we_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        uart_we_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      uart_we_q <= 1'b0;
      uart_di_q <= '0;
    end else begin
      state_q   <= state_d;
      uart_we_q <= uart_we_d;
      uart_di_q <= uart_di_d;
    end
  end

endmodule

// File: tb/tb_usb_uart_tx_buffer.sv
// Self-checking bench for usb_uart_tx_buffer: scenario tasks plus a randomized run
// compared against a byte-order scoreboard of written versus accepted bytes.
module tb_usb_uart_tx_buffer;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk_48mhz = 1'b0;
  logic          resetn    = 1'b0;
  logic [7:0]    in_data   = 8'h00;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [AW:0]   level;
  logic          empty;
  logic          full;
  logic [7:0]    uart_di;
  logic          uart_we;
  logic          uart_wait = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Written only by the monitor; tasks work from snapshots of the sizes.
  logic [7:0] wr_log[$];
  logic [7:0] acc_log[$];
  int         b2b_cnt  = 0;
  logic       acc_prev = 1'b0;

  usb_uart_tx_buffer #(.DEPTH(DEPTH)) dut (
    .clk_48mhz (clk_48mhz),
    .resetn    (resetn),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .level     (level),
    .empty     (empty),
    .full      (full),
    .uart_di   (uart_di),
    .uart_we   (uart_we),
    .uart_wait (uart_wait)
  );

  always #5 clk_48mhz = ~clk_48mhz;

  always @(posedge clk_48mhz) begin
    if (resetn) begin
      if (in_valid && in_ready) wr_log.push_back(in_data);
      if (uart_we && !uart_wait) begin
        if (acc_prev) b2b_cnt++;
        acc_log.push_back(uart_di);
        acc_prev = 1'b1;
      end else begin
        acc_prev = 1'b0;
      end
    end else begin
      acc_prev = 1'b0;
    end
  end

  task automatic tick();
    @(negedge clk_48mhz);
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    uart_wait = 1'b0;
    resetn    = 1'b0;
    tick();
    resetn    = 1'b1;
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    in_data   = 8'h00;
    uart_wait = 1'b0;
    resetn    = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    n_cmp++; if (uart_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", uart_we); end
    n_cmp++; if (uart_di !== 8'h00) begin n_err++; $display("FAIL reset_di got=%h exp=00", uart_di); end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_idle();
    do_reset();
    for (int c = 0; c < 100; c++) begin
      tick();
      n_cmp++;
      if (uart_we !== 1'b0 || level !== 5'd0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL idle cyc=%0d we=%b level=%0d in_ready=%b exp we=0 level=0 in_ready=1",
                 c, uart_we, level, in_ready);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'h48;
    tick();                       // cycle 1
    in_valid = 1'b0;
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_c1_empty got=%b exp=0", empty); end
    n_cmp++; if (uart_we !== 1'b0) begin n_err++; $display("FAIL single_c1_we got=%b exp=0", uart_we); end
    tick();                       // cycle 2
    n_cmp++; if (uart_we !== 1'b0) begin n_err++; $display("FAIL single_c2_we got=%b exp=0", uart_we); end
    tick();                       // cycle 3
    n_cmp++; if (uart_we !== 1'b1) begin n_err++; $display("FAIL single_c3_we got=%b exp=1", uart_we); end
    n_cmp++; if (uart_di !== 8'h48) begin n_err++; $display("FAIL single_c3_di got=%h exp=48", uart_di); end
    tick();                       // cycle 4
    n_cmp++; if (uart_we !== 1'b0) begin n_err++; $display("FAIL single_c4_we got=%b exp=0", uart_we); end
  endtask

  task automatic test_burst();
    string      s;
    logic [7:0] msg [13];
    int         idx, wcnt, drops, base_a, b2b0, cyc;
    s = "Hello World!\n";
    for (int i = 0; i < 13; i++) msg[i] = s[i];
    do_reset();
    base_a = acc_log.size();
    b2b0   = b2b_cnt;
    idx = 0; wcnt = 0; drops = 0; cyc = 0;
    while ((acc_log.size() - base_a) < 13 && cyc < 600) begin
      if (!in_ready) drops++;
      if (wcnt > 0) begin uart_wait = 1'b1; wcnt--; end
      else uart_wait = 1'b0;
      if (uart_we && !uart_wait) wcnt = 5;
      if (idx < 13) begin
        in_valid = 1'b1;
        in_data  = msg[idx];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    uart_wait = 1'b0;
    n_cmp++;
    if ((acc_log.size() - base_a) != 13) begin
      n_err++; $display("FAIL burst_count got=%0d exp=13", acc_log.size() - base_a);
    end else begin
      for (int i = 0; i < 13; i++) begin
        n_cmp++;
        if (acc_log[base_a+i] !== msg[i]) begin
          n_err++; $display("FAIL burst_byte%0d got=%h exp=%h", i, acc_log[base_a+i], msg[i]);
        end
      end
    end
    n_cmp++; if (b2b_cnt != b2b0) begin n_err++; $display("FAIL burst_b2b got=%0d exp=0", b2b_cnt - b2b0); end
    n_cmp++; if (drops != 0) begin n_err++; $display("FAIL burst_in_ready_drops got=%0d exp=0", drops); end
  endtask

  // The drain FSM pops one byte into FETCH while uart_wait is stuck, so the
  // FIFO itself fills on the DEPTH+1-th write and the next write stalls.
  task automatic test_fill();
    logic [7:0] d [DEPTH+2];
    int         base_w, base_a, cyc, exp_lvl;
    for (int i = 0; i < DEPTH + 2; i++) d[i] = 8'($urandom);
    do_reset();
    uart_wait = 1'b1;
    base_w = wr_log.size();
    base_a = acc_log.size();
    for (int k = 0; k <= DEPTH; k++) begin
      in_valid = 1'b1;
      in_data  = d[k];
      tick();
      exp_lvl = (k == 0) ? 1 : k;
      n_cmp++;
      if (int'(level) != exp_lvl) begin
        n_err++; $display("FAIL fill_level_after_%0d got=%0d exp=%0d", k + 1, level, exp_lvl);
      end
    end
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", full); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
    in_data = d[DEPTH+1];
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (in_ready !== 1'b0 || int'(level) != DEPTH) begin
        n_err++; $display("FAIL fill_stall in_ready=%b level=%0d exp in_ready=0 level=%0d", in_ready, level, DEPTH);
      end
    end
    n_cmp++;
    if ((wr_log.size() - base_w) != DEPTH + 1) begin
      n_err++; $display("FAIL fill_stalled_writes got=%0d exp=%0d", wr_log.size() - base_w, DEPTH + 1);
    end
    uart_wait = 1'b0;
    cyc = 0;
    while (!in_ready && cyc < 100) begin tick(); cyc++; end
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while ((acc_log.size() - base_a) < DEPTH + 2 && cyc < 300) begin tick(); cyc++; end
    n_cmp++;
    if ((acc_log.size() - base_a) != DEPTH + 2) begin
      n_err++; $display("FAIL fill_out_count got=%0d exp=%0d", acc_log.size() - base_a, DEPTH + 2);
    end else begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        n_cmp++;
        if (acc_log[base_a+i] !== d[i]) begin
          n_err++; $display("FAIL fill_byte%0d got=%h exp=%h", i, acc_log[base_a+i], d[i]);
        end
      end
    end
  endtask

  task automatic test_wait_strobe();
    logic [7:0] b, hold_di;
    int         cyc, base_a;
    b = 8'($urandom);
    do_reset();
    base_a   = acc_log.size();
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!uart_we && cyc < 20) begin tick(); cyc++; end
    n_cmp++; if (uart_we !== 1'b1) begin n_err++; $display("FAIL wstrobe_timeout we=%b exp=1", uart_we); end
    uart_wait = 1'b1;
    hold_di   = uart_di;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (uart_we !== 1'b1 || uart_di !== hold_di) begin
        n_err++; $display("FAIL wstrobe_hold cyc=%0d we=%b di=%h exp we=1 di=%h", c, uart_we, uart_di, hold_di);
      end
    end
    uart_wait = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if ((acc_log.size() - base_a) != 1) begin
      n_err++; $display("FAIL wstrobe_accepts got=%0d exp=1", acc_log.size() - base_a);
    end else begin
      n_cmp++;
      if (acc_log[base_a] !== b) begin n_err++; $display("FAIL wstrobe_byte got=%h exp=%h", acc_log[base_a], b); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] nb;
    int         cyc, base_a;
    do_reset();
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!uart_we && cyc < 20) begin tick(); cyc++; end
    uart_wait = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      tick();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (uart_we !== 1'b1 || level !== 5'd5) begin
      n_err++; $display("FAIL rstmid_setup we=%b level=%0d exp we=1 level=5", uart_we, level);
    end
    base_a = acc_log.size();
    resetn = 1'b0;
    tick();
    resetn    = 1'b1;
    uart_wait = 1'b0;
    n_cmp++; if (uart_we !== 1'b0) begin n_err++; $display("FAIL rstmid_we got=%b exp=0", uart_we); end
    n_cmp++; if (level !== 5'd0) begin n_err++; $display("FAIL rstmid_level got=%0d exp=0", level); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
    repeat (30) tick();
    n_cmp++;
    if (acc_log.size() != base_a) begin
      n_err++; $display("FAIL rstmid_stale got=%0d exp=0", acc_log.size() - base_a);
    end
    nb = 8'($urandom);
    in_valid = 1'b1;
    in_data  = nb;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    n_cmp++;
    if ((acc_log.size() - base_a) != 1) begin
      n_err++; $display("FAIL rstmid_after_count got=%0d exp=1", acc_log.size() - base_a);
    end else begin
      n_cmp++;
      if (acc_log[base_a] !== nb) begin n_err++; $display("FAIL rstmid_after_byte got=%h exp=%h", acc_log[base_a], nb); end
    end
  endtask

  // Randomized traffic: stored + held bytes must equal written - accepted,
  // with exactly one byte held whenever uart_we is up, and order preserved.
  task automatic test_random();
    int         base_w, base_a, pct, held, cyc, nw;
    logic       prev_hold;
    logic [7:0] prev_di;
    do_reset();
    base_w    = wr_log.size();
    base_a    = acc_log.size();
    prev_hold = 1'b0;
    prev_di   = 8'h00;
    for (int c = 0; c < 800; c++) begin
      if (prev_hold) begin
        n_cmp++;
        if (uart_we !== 1'b1 || uart_di !== prev_di) begin
          n_err++; $display("FAIL rand_hold cyc=%0d we=%b di=%h exp we=1 di=%h", c, uart_we, uart_di, prev_di);
        end
      end
      n_cmp++;
      if (full !== (int'(level) == DEPTH) || empty !== (level == 5'd0) || in_ready !== !full) begin
        n_err++; $display("FAIL rand_flags cyc=%0d level=%0d full=%b empty=%b in_ready=%b", c, level, full, empty, in_ready);
      end
      held = (wr_log.size() - base_w) - (acc_log.size() - base_a) - int'(level);
      n_cmp++;
      if (held < 0 || held > 1 || (uart_we && held != 1)) begin
        n_err++; $display("FAIL rand_occupancy cyc=%0d held=%0d we=%b exp held 0..1 (1 when we)", c, held, uart_we);
      end
      pct       = (c < 400) ? 75 : 20;
      uart_wait = ($urandom_range(99) < pct);
      in_valid  = $urandom_range(1) == 1;
      in_data   = 8'($urandom);
      prev_hold = uart_we && uart_wait;
      prev_di   = uart_di;
      tick();
    end
    in_valid  = 1'b0;
    uart_wait = 1'b0;
    nw  = wr_log.size() - base_w;
    cyc = 0;
    while ((acc_log.size() - base_a) < nw && cyc < 200) begin tick(); cyc++; end
    n_cmp++;
    if ((acc_log.size() - base_a) != nw || nw == 0) begin
      n_err++; $display("FAIL rand_count got=%0d exp=%0d", acc_log.size() - base_a, nw);
    end else begin
      for (int i = 0; i < nw; i++) begin
        n_cmp++;
        if (acc_log[base_a+i] !== wr_log[base_w+i]) begin
          n_err++; $display("FAIL rand_byte%0d got=%h exp=%h", i, acc_log[base_a+i], wr_log[base_w+i]);
        end
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_idle();
    test_single();
    test_burst();
    test_fill();
    test_wait_strobe();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
